// File: rtl/elevator3_pkg.sv
// Shared definitions for the three-floor elevator controller.
//   state_t      : controller states (idle, travelling up/down, door open)
//   dir_t        : last travel direction, used as the SCAN preference
//   FLOOR0..2    : floor codes as presented to the display
//   floor_onehot : floor code -> one-hot call/serve mask
//   above_mask / below_mask : call bits strictly above / below a floor
package elevator3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam logic [1:0] FLOOR0 = 2'b00;
  localparam logic [1:0] FLOOR1 = 2'b01;
  localparam logic [1:0] FLOOR2 = 2'b10;

  function automatic logic [2:0] floor_onehot(input logic [1:0] f);
    case (f)
      FLOOR0:  floor_onehot = 3'b001;
      FLOOR1:  floor_onehot = 3'b010;
      FLOOR2:  floor_onehot = 3'b100;
      default: floor_onehot = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] above_mask(input logic [1:0] f);
    case (f)
      FLOOR0:  above_mask = 3'b110;
      FLOOR1:  above_mask = 3'b100;
      default: above_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_mask(input logic [1:0] f);
    case (f)
      FLOOR1:  below_mask = 3'b001;
      FLOOR2:  below_mask = 3'b011;
      default: below_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Square-wave divider for the moving-warning blink.
//   clock   : system clock
//   reset_n : synchronous active-low reset (level returns high)
//   restart : restart the pattern; level is high for the next BLINK_HALF cycles
//   enable  : run the divider; when low the output is held high
//   level   : registered blink output, toggles every BLINK_HALF enabled cycles
module blink_gen #(
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  input  logic enable,
  output logic level
);

  localparam logic [31:0] HALF_LAST = 32'(BLINK_HALF - 1);

  logic [31:0] cnt_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      level   <= 1'b1;
    end else if (restart || !enable) begin
      cnt_reg <= '0;
      level   <= 1'b1;
    end else if (cnt_reg == HALF_LAST) begin
      cnt_reg <= '0;
      level   <= ~level;
    end else begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

endmodule

// File: rtl/elevator3_floor_ctrl.sv
// Three-floor elevator controller: latches calls, schedules travel with a
// direction-preserving (SCAN) policy, times travel and door dwell, and drives
// the floor code and blinking display enable for the 7-segment display.
//   clock      : system clock, rising edge
//   reset_n    : synchronous active-low reset
//   call_req   : call buttons, bit k = floor k
//   floor_code : current floor to the display (00, 01, 10)
//   disp_en    : display enable; blinks while the car moves
//   motor_up   : car moving up
//   motor_down : car moving down
//   door_open  : door open
//   pending    : latched outstanding calls
module elevator3_floor_ctrl
  import elevator3_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000,
  parameter int BLINK_HALF    = 12_500_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] call_req,
  output logic [1:0] floor_code,
  output logic       disp_en,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam logic [31:0] TRAVEL_LAST = 32'(TRAVEL_CYCLES - 1);
  localparam logic [31:0] DOOR_LAST   = 32'(DOOR_CYCLES - 1);

  state_t      state_reg, state_next;
  dir_t        dir_reg, dir_next;
  logic [1:0]  floor_reg, floor_next;
  logic [2:0]  pending_reg, pending_next;
  logic [31:0] cnt_reg, cnt_next;   // shared travel / dwell counter
  logic        motor_up_reg, motor_down_reg, door_open_reg;

  logic [2:0]  served;
  logic [2:0]  call_mask;
  logic [1:0]  arrived;
  logic        has_here, has_above, has_below, has_beyond;
  logic        blink_restart, blink_enable;

  assign has_here  = |(pending_reg & floor_onehot(floor_reg));
  assign has_above = |(pending_reg & above_mask(floor_reg));
  assign has_below = |(pending_reg & below_mask(floor_reg));

  // Floor reached at the end of the current travel period.
  assign arrived    = (state_reg == ST_UP) ? floor_reg + 2'd1 : floor_reg - 2'd1;
  assign has_beyond = (state_reg == ST_UP) ? |(pending_reg & above_mask(arrived))
                                           : |(pending_reg & below_mask(arrived));

  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    floor_next = floor_reg;
    cnt_next   = cnt_reg;
    served     = 3'b000;
    call_mask  = 3'b111;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (has_here) begin
          state_next = ST_DOOR;
          served     = floor_onehot(floor_reg);
        end else if (has_above && (dir_reg == DIR_UP || !has_below)) begin
          state_next = ST_UP;
          dir_next   = DIR_UP;
        end else if (has_below) begin
          state_next = ST_DOWN;
          dir_next   = DIR_DOWN;
        end
      end
      ST_UP, ST_DOWN: begin
        if (cnt_reg == TRAVEL_LAST) begin
          cnt_next   = '0;
          floor_next = arrived;
          if (|(pending_reg & floor_onehot(arrived))) begin
            state_next = ST_DOOR;
            served     = floor_onehot(arrived);
          end else if (!has_beyond) begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      ST_DOOR: begin
        // A press at the open floor extends the dwell instead of latching.
        call_mask = ~floor_onehot(floor_reg);
        if (|(call_req & floor_onehot(floor_reg))) begin
          cnt_next = '0;
        end else if (cnt_reg == DOOR_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    pending_next = (pending_reg | (call_req & call_mask)) & ~served;
  end

  // The blink pattern starts fresh only when a move begins from IDLE;
  // continuing through an intermediate floor keeps the running phase.
  assign blink_enable  = (state_next == ST_UP) || (state_next == ST_DOWN);
  assign blink_restart = (state_reg == ST_IDLE) && blink_enable;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      dir_reg        <= DIR_UP;
      floor_reg      <= FLOOR0;
      pending_reg    <= 3'b000;
      cnt_reg        <= '0;
      motor_up_reg   <= 1'b0;
      motor_down_reg <= 1'b0;
      door_open_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      floor_reg      <= floor_next;
      pending_reg    <= pending_next;
      cnt_reg        <= cnt_next;
      motor_up_reg   <= (state_next == ST_UP);
      motor_down_reg <= (state_next == ST_DOWN);
      door_open_reg  <= (state_next == ST_DOOR);
    end
  end

  blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clock  (clock),
    .reset_n(reset_n),
    .restart(blink_restart),
    .enable (blink_enable),
    .level  (disp_en)
  );

  assign floor_code = floor_reg;
  assign pending    = pending_reg;
  assign motor_up   = motor_up_reg;
  assign motor_down = motor_down_reg;
  assign door_open  = door_open_reg;

endmodule

// File: tb/tb_elevator3_floor_ctrl.sv
// Scoreboard bench for elevator3_floor_ctrl. The driver applies one input
// vector per cycle, advances a behavioural model of the elevator and pushes
// the expected outputs; the monitor pops and compares on the falling edge.
module tb_elevator3_floor_ctrl;

  localparam int T  = 8;
  localparam int D  = 4;
  localparam int BH = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] call_req = 3'b000;
  logic [1:0] floor_code;
  logic       disp_en, motor_up, motor_down, door_open;
  logic [2:0] pending;

  elevator3_floor_ctrl #(
    .TRAVEL_CYCLES(T),
    .DOOR_CYCLES  (D),
    .BLINK_HALF   (BH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .call_req  (call_req),
    .floor_code(floor_code),
    .disp_en   (disp_en),
    .motor_up  (motor_up),
    .motor_down(motor_down),
    .door_open (door_open),
    .pending   (pending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] fc;
    logic       de;
    logic       mu;
    logic       md;
    logic       dr;
    logic [2:0] pd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Behavioural model: floor as an integer, travel/dwell as cycles remaining,
  // blink from cycles elapsed since the move began.
  int       m_floor = 0;
  bit       m_moving = 0;
  bit       m_door = 0;
  int       m_step = 1;
  bit       m_last_up = 1;
  int       m_left = 0;
  int       m_since = 0;
  bit [2:0] m_pend = 3'b000;

  task automatic model_step(input logic [2:0] req, input logic rst);
    int  served;
    int  nf;
    int  fl0;
    bit  door0, above, below, beyond;
    bit [2:0] old;
    if (!rst) begin
      m_floor = 0; m_moving = 0; m_door = 0; m_step = 1; m_last_up = 1;
      m_left = 0; m_since = 0; m_pend = 3'b000;
      return;
    end
    served = -1;
    fl0 = m_floor;
    door0 = m_door;
    old = m_pend;
    above = 0;
    below = 0;
    for (int f = 0; f < 3; f++) begin
      if (old[f] && f > m_floor) above = 1;
      if (old[f] && f < m_floor) below = 1;
    end
    if (m_door) begin
      if (req[m_floor]) m_left = D;
      else begin
        m_left--;
        if (m_left == 0) m_door = 0;
      end
    end else if (m_moving) begin
      m_left--;
      m_since++;
      if (m_left == 0) begin
        nf = m_floor + m_step;
        m_floor = nf;
        beyond = 0;
        for (int f = 0; f < 3; f++)
          if (old[f] && (f - nf) * m_step > 0) beyond = 1;
        if (old[nf]) begin
          m_moving = 0; m_door = 1; m_left = D; served = nf;
        end else if (beyond) begin
          m_left = T;
        end else begin
          m_moving = 0;
        end
      end
    end else begin
      if (old[m_floor]) begin
        m_door = 1; m_left = D; served = m_floor;
      end else if (above && (m_last_up || !below)) begin
        m_moving = 1; m_step = 1; m_last_up = 1; m_left = T; m_since = 0;
      end else if (below) begin
        m_moving = 1; m_step = -1; m_last_up = 0; m_left = T; m_since = 0;
      end
    end
    for (int f = 0; f < 3; f++) begin
      bit latch;
      latch = req[f] && !(door0 && f == fl0);
      m_pend[f] = (old[f] || latch) && (f != served);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.fc = 2'(m_floor);
    e.de = m_moving ? (((m_since / BH) % 2) == 0) : 1'b1;
    e.mu = m_moving && m_step == 1;
    e.md = m_moving && m_step == -1;
    e.dr = m_door;
    e.pd = m_pend;
    return e;
  endfunction

  task automatic tick(input logic [2:0] req, input logic rst);
    call_req = req;
    reset_n  = rst;
    @(posedge clock);
    model_step(req, rst);
    sb.push_back(model_out());
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cycle, got, want);
    end
  endtask

  // Monitor: every falling edge the DUT presents one registered output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("floor_code", {2'b00, floor_code}, {2'b00, e.fc});
        chk("disp_en",    {3'b000, disp_en},   {3'b000, e.de});
        chk("motor_up",   {3'b000, motor_up},  {3'b000, e.mu});
        chk("motor_down", {3'b000, motor_down},{3'b000, e.md});
        chk("door_open",  {3'b000, door_open}, {3'b000, e.dr});
        chk("pending",    {1'b0, pending},     {1'b0, e.pd});
        chk("motor_overlap", {3'b000, motor_up & motor_down}, 4'h0);
      end
    end
  end

  initial begin
    bit found;
    logic [2:0] r;

    // Reset held with all buttons pressed.
    repeat (3) tick(3'b111, 1'b0);
    $display("reset phase done");

    // Call floor 2 from floor 0.
    tick(3'b100, 1'b1);
    repeat (40) tick(3'b000, 1'b1);
    $display("call floor 2 from floor 0 done");

    // SCAN: go back to floor 0, then call 2 and, while moving up, call 0.
    repeat (3) tick(3'b111, 1'b0);
    tick(3'b100, 1'b1);
    repeat (3) tick(3'b000, 1'b1);
    tick(3'b001, 1'b1);
    repeat (60) tick(3'b000, 1'b1);
    $display("scan preference phase done");

    // Door restart at floor 0: open the door, press floor 0 again mid-dwell.
    tick(3'b001, 1'b1);
    tick(3'b000, 1'b1);   // door opens on this edge
    tick(3'b000, 1'b1);
    tick(3'b001, 1'b1);   // restart
    repeat (10) tick(3'b000, 1'b1);
    $display("door restart phase done");

    // Reset mid-travel while moving down at floor 1.
    tick(3'b100, 1'b1);
    repeat (30) tick(3'b000, 1'b1);
    tick(3'b001, 1'b1);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_moving && m_step == -1 && m_floor == 1) found = 1;
      else tick(3'b000, 1'b1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_down_floor1 got not_reached expected reached");
    end
    tick(3'b111, 1'b0);
    repeat (5) tick(3'b000, 1'b1);
    $display("reset mid-travel phase done");

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      tick(r, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end
    $display("random phase done");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
